led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
- Consumer end of the 16x16 red/green pixel-array interface that the traffic-light state machines produce.
- Takes a full frame of RedPixels and GrnPixels and scans it out one row at a time to a row-multiplexed bicolour LED matrix.
- Each row gets a blanking interval, to prevent ghosting, followed by a drive interval.
- A frame is snapshotted into shadow registers at each frame start, so producer updates never tear a frame.

Parameters:
- DWELL_CYCLES, 1000: clk cycles each row is driven; must be >= 1.
- BLANK_CYCLES, 16: clk cycles of all-off before each row is driven; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan enable, sampled every clk edge.
- RedPixels  input  [15:0][15:0]  red frame; RedPixels[r][c] is row r, column c; bit 15 is column F.
- GrnPixels  input  [15:0][15:0]  green frame, same indexing as RedPixels.
- row_sel  output  16  one-hot active-high row select; all zero when not driving.
- red_col  output  16  red column data for the selected row.
- grn_col  output  16  green column data for the selected row.
- row_idx  output  4  current scan row.
- frame_start  output  1  one-cycle pulse on the first BLANK cycle of row 0.

Behaviour:
- One clock domain. Reset is synchronous and active-high and has priority over enable.
- Reset values: state=IDLE, row_idx=0, cnt=0, shadow_red=0, shadow_grn=0, row_sel=0, red_col=0, grn_col=0, frame_start=0.
- Outputs are decoded only from registers (state, row_idx, shadow). There is no combinational path from any input to any output.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - All outputs 0.
  - If enable=1: go to BLANK with row_idx=0 and cnt=0, and load shadow_red<=RedPixels and shadow_grn<=GrnPixels on that same edge.
- BLANK:
  - row_sel=0, red_col=0, grn_col=0.
  - cnt increments each cycle.
  - When cnt==BLANK_CYCLES-1: go to DRIVE with cnt=0.
  - BLANK therefore lasts exactly BLANK_CYCLES cycles.
- DRIVE:
  - row_sel = 1<<row_idx.
  - red_col = shadow_red[row_idx], grn_col = shadow_grn[row_idx].
  - When cnt==DWELL_CYCLES-1: go to BLANK with cnt=0 and row_idx<=row_idx+1, wrapping 15->0.
  - On the wrap 15->0, reload both shadow arrays from the inputs on the same edge.
- frame_start=1 exactly during the first BLANK cycle of row 0, whether entered from IDLE or from the 15->0 wrap. It is 0 at all other times.
- Frame period = 16*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- enable=0 in BLANK or DRIVE: go to IDLE on the next edge, with row_idx=0 and cnt=0. The shadow arrays are retained but unused. When enable reasserts, a new frame starts at row 0 with a fresh snapshot.
- Input changes between snapshots are ignored until the next frame start.
- Red and green bits that are both set are both driven (yellow); no arbitration.
- Reset asserted mid-operation: the next edge gives the reset values regardless of enable. After reset releases with enable=1, the following edge enters BLANK row 0.
- cnt width is $clog2 of max(DWELL_CYCLES, BLANK_CYCLES), minimum 1 bit.

Test Plan:
All scenarios use DWELL_CYCLES=4 and BLANK_CYCLES=2.
- Startup: reset, then enable=1, RedPixels[0]=16'h01C0, GrnPixels[0]=0.
  - row_sel=0 for 2 cycles with frame_start=1 on the first of them.
  - Then row_sel=16'h0001 and red_col=16'h01C0 for 4 cycles.
  - Then row_sel=0 for 2 cycles, then row_sel=16'h0002.
- Wrap: run continuously.
  - After the row 15 DRIVE (row_sel=16'h8000 for 4 cycles), BLANK of row 0 follows with frame_start=1.
  - Successive frame_start pulses are exactly 96 cycles apart.
- Snapshot: change RedPixels[5] from 0 to 16'hFFFF while row 2 is in DRIVE.
  - During row 5 DRIVE, red_col=0.
  - During row 5 DRIVE of the next frame, red_col=16'hFFFF.
- Enable drop: deassert enable in cycle 2 of row 7 DRIVE.
  - Next cycle all outputs are 0 and row_idx=0.
  - Reassert: the next cycle is BLANK row 0 with frame_start=1.
- Reset mid-scan: assert reset during row 3 DRIVE with enable=1.
  - Next cycle all outputs are 0.
  - Release reset: the next cycle is BLANK row 0 with frame_start=1.
- Bicolour: RedPixels[0]=GrnPixels[0]=16'h01C0.
  - In row 0 DRIVE, red_col=grn_col=16'h01C0 and row_sel=16'h0001.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed scan driver for a 16x16 bicolour LED matrix. Each row gets a
// blanking interval and then a drive interval. Frames are snapshotted at frame start.
module led_matrix_scanner #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0][15:0] RedPixels,
  input  logic [15:0][15:0] GrnPixels,
  output logic [15:0]       row_sel,
  output logic [15:0]       red_col,
  output logic [15:0]       grn_col,
  output logic [3:0]        row_idx,
  output logic              frame_start
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        row_q, row_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              load_shadow;
  logic [15:0][15:0] shadow_red_q, shadow_grn_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    load_shadow = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = BLANK;
          row_d       = 4'd0;
          cnt_d       = '0;
          load_shadow = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          row_d   = 4'd0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_d = IDLE;
          row_d   = 4'd0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          state_d     = BLANK;
          cnt_d       = '0;
          row_d       = row_q + 4'd1;
          // Wrapping past row 15 begins a new frame, which needs a fresh snapshot.
          load_shadow = (row_q == 4'd15);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the shadow frame is cleared by reset as well, so nothing stale is shown after a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_red_q <= '0;
      shadow_grn_q <= '0;
    end else if (load_shadow) begin
      shadow_red_q <= RedPixels;
      shadow_grn_q <= GrnPixels;
    end
  end

  // All outputs are decoded from registers only.
  always_comb begin
    row_sel     = 16'd0;
    red_col     = 16'd0;
    grn_col     = 16'd0;
    row_idx     = row_q;
    frame_start = (state_q == BLANK) && (row_q == 4'd0) && (cnt_q == '0);
    if (state_q == DRIVE) begin
      row_sel = 16'd1 << row_q;
      red_col = shadow_red_q[row_q];
      grn_col = shadow_grn_q[row_q];
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner with DWELL_CYCLES=4 and BLANK_CYCLES=2.
// Table-driven startup vectors, followed by hand-written multi-cycle sequences.
module tb_led_matrix_scanner;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic [15:0]       row_sel;
  logic [15:0]       red_col;
  logic [15:0]       grn_col;
  logic [3:0]        row_idx;
  logic              frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  led_matrix_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .RedPixels   (RedPixels),
    .GrnPixels   (GrnPixels),
    .row_sel     (row_sel),
    .red_col     (red_col),
    .grn_col     (grn_col),
    .row_idx     (row_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] rs;
    logic [15:0] red;
    logic [15:0] grn;
    logic [3:0]  ri;
    logic        fs;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change just after an edge, and outputs are sampled at that same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drive(input int row);
    int n;
    n = 0;
    while (row_sel !== (16'd1 << row) && n < 200) begin
      step();
      n++;
    end
    check($sformatf("reach_drive_row%0d", row), 32'(row_sel), 32'(16'd1 << row));
  endtask

  task automatic wait_frame_start(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (frame_start !== 1'b1 && cycles < 300);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0001, 16'h01C0, 16'h0000, 4'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0001, 16'h01C0, 16'h0000, 4'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h0001, 16'h01C0, 16'h0000, 4'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0001, 16'h01C0, 16'h0000, 4'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 4'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 4'd1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0000, 4'd1, 1'b0};

    reset     = 1'b1;
    enable    = 1'b0;
    RedPixels = '0;
    GrnPixels = '0;
    RedPixels[0] = 16'h01C0;

    // Startup vectors: reset, reset priority over enable, then the row 0 and row 1 timing.
    for (int i = 0; i < 11; i++) begin
      reset  = vecs[i].rst;
      enable = vecs[i].en;
      step();
      check($sformatf("v%0d_row_sel", i),     32'(row_sel),     32'(vecs[i].rs));
      check($sformatf("v%0d_red_col", i),     32'(red_col),     32'(vecs[i].red));
      check($sformatf("v%0d_grn_col", i),     32'(grn_col),     32'(vecs[i].grn));
      check($sformatf("v%0d_row_idx", i),     32'(row_idx),     32'(vecs[i].ri));
      check($sformatf("v%0d_frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
    end

    // Wrap: row 15 drives for 4 cycles, then row 0 blanks with frame_start.
    wait_drive(15);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("wrap_row15_drive%0d", i + 1), 32'(row_sel), 32'h8000);
    end
    step();
    check("wrap_blank_row_sel",    32'(row_sel),     32'h0);
    check("wrap_blank_row_idx",    32'(row_idx),     32'h0);
    check("wrap_blank_frame_start", 32'(frame_start), 32'h1);
    wait_frame_start(n);
    check("frame_period", 32'(n), 32'd96);

    // Snapshot: a mid-frame input change only shows up in the next frame.
    wait_drive(2);
    RedPixels[5] = 16'hFFFF;
    wait_drive(5);
    check("snapshot_old_frame", 32'(red_col), 32'h0);
    wait_frame_start(n);
    wait_drive(5);
    check("snapshot_new_frame", 32'(red_col), 32'hFFFF);

    // Enable drop during cycle 2 of the row 7 drive.
    wait_drive(7);
    step();
    enable = 1'b0;
    step();
    check("endrop_row_sel",     32'(row_sel),     32'h0);
    check("endrop_red_col",     32'(red_col),     32'h0);
    check("endrop_grn_col",     32'(grn_col),     32'h0);
    check("endrop_row_idx",     32'(row_idx),     32'h0);
    check("endrop_frame_start", 32'(frame_start), 32'h0);
    enable = 1'b1;
    step();
    check("enre_frame_start", 32'(frame_start), 32'h1);
    check("enre_row_sel",     32'(row_sel),     32'h0);
    check("enre_row_idx",     32'(row_idx),     32'h0);

    // Reset during the row 3 drive, then a bicolour row 0 on the following frame.
    wait_drive(3);
    reset = 1'b1;
    step();
    check("rst_row_sel",     32'(row_sel),     32'h0);
    check("rst_red_col",     32'(red_col),     32'h0);
    check("rst_row_idx",     32'(row_idx),     32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    reset        = 1'b0;
    GrnPixels[0] = 16'h01C0;
    step();
    check("rstrel_frame_start", 32'(frame_start), 32'h1);
    check("rstrel_row_idx",     32'(row_idx),     32'h0);
    check("rstrel_row_sel",     32'(row_sel),     32'h0);
    wait_drive(0);
    check("bicolour_red", 32'(red_col), 32'h01C0);
    check("bicolour_grn", 32'(grn_col), 32'h01C0);
    check("bicolour_row_sel", 32'(row_sel), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
